// File: rtl/i2c_xfer_sequencer_if.sv
// Wishbone link between the transfer sequencer and the I2C master core's
// 8-bit register file.
//   master modport : sequencer side (drives address/data/controls)
//   slave modport  : core side (returns read data and acknowledge)
// Signals:
//   m_adr_o  core register address
//   m_dat_o  write data to the core
//   m_dat_i  read data from the core
//   m_we_o   write enable
//   m_stb_o  strobe
//   m_cyc_o  cycle
//   m_ack_i  acknowledge from the core
interface i2c_xfer_sequencer_if;
    logic [2:0] m_adr_o;
    logic [7:0] m_dat_o;
    logic [7:0] m_dat_i;
    logic       m_we_o;
    logic       m_stb_o;
    logic       m_cyc_o;
    logic       m_ack_i;

    modport master (
        output m_adr_o, m_dat_o, m_we_o, m_stb_o, m_cyc_o,
        input  m_dat_i, m_ack_i
    );

    modport slave (
        input  m_adr_o, m_dat_o, m_we_o, m_stb_o, m_cyc_o,
        output m_dat_i, m_ack_i
    );
endinterface

// File: rtl/i2c_xfer_sequencer.sv
// Microsequencer that turns single-byte register requests into the
// command/poll sequence of the I2C master core. After reset it programs the
// prescaler and enables the core, then serves one request at a time and
// returns read data or an error code.
// Ports:
//   wb_clk_i, arst_i          clock, asynchronous active-low reset
//   req_valid_i/req_ready_o   request handshake
//   req_rnw_i                 1 = read, 0 = write
//   req_dev_i, req_reg_i      7-bit device address, 8-bit register address
//   req_wdata_i               write data
//   rsp_valid_o               one-cycle completion pulse
//   rsp_rdata_o, rsp_err_o    read data / error (00 ok, 01 NACK, 10 AL, 11 timeout)
//   init_done_o               core initialisation finished
//   wb                        Wishbone master link to the core
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_INIT  | write PRERlo, PRERhi, CTR (step_q selects which)
// ST_IDLE  | ready for a request
// ST_TXR   | write TXR for the current step
// ST_CR    | write CR for the current step
// ST_WAIT  | poll SR until TIP clears, then check AL / RxACK
// ST_STO   | write CR = STO after a NACK
// ST_DRAIN | poll SR until the bus is no longer busy
// ST_RXR   | read the received byte
// ST_RESP  | completion pulse
module i2c_xfer_sequencer #(
    parameter logic [15:0] PRESCALE = 16'h0031,
    parameter int unsigned POLL_MAX = 1024
) (
    input  logic                  wb_clk_i,
    input  logic                  arst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_rnw_i,
    input  logic [6:0]            req_dev_i,
    input  logic [7:0]            req_reg_i,
    input  logic [7:0]            req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [7:0]            rsp_rdata_o,
    output logic [1:0]            rsp_err_o,
    output logic                  init_done_o,
    i2c_xfer_sequencer_if.master  wb
);

    localparam logic [3:0] ST_INIT  = 4'd0;
    localparam logic [3:0] ST_IDLE  = 4'd1;
    localparam logic [3:0] ST_TXR   = 4'd2;
    localparam logic [3:0] ST_CR    = 4'd3;
    localparam logic [3:0] ST_WAIT  = 4'd4;
    localparam logic [3:0] ST_STO   = 4'd5;
    localparam logic [3:0] ST_DRAIN = 4'd6;
    localparam logic [3:0] ST_RXR   = 4'd7;
    localparam logic [3:0] ST_RESP  = 4'd8;

    localparam logic [2:0] ADR_TXR = 3'd3;   // RXR on read
    localparam logic [2:0] ADR_CR  = 3'd4;   // SR on read

    localparam logic [7:0] CR_STA_WR      = 8'h90;
    localparam logic [7:0] CR_WR          = 8'h10;
    localparam logic [7:0] CR_STO_WR      = 8'h50;
    localparam logic [7:0] CR_RD_NACK_STO = 8'h68;
    localparam logic [7:0] CR_STO         = 8'h40;
    localparam logic [7:0] CTR_EN         = 8'h80;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_NACK = 2'b01;
    localparam logic [1:0] ERR_AL   = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;

    localparam int unsigned PCW = $clog2(POLL_MAX + 1);
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_MAX - 1);

    logic [3:0]     state_q;
    logic [1:0]     step_q;
    logic [PCW-1:0] poll_q;
    logic [1:0]     err_q;
    logic           rnw_q;
    logic [6:0]     dev_q;
    logic [7:0]     reg_q;
    logic [7:0]     wdata_q;

    logic           stb_q;
    logic           we_q;
    logic [2:0]     adr_q;
    logic [7:0]     dat_q;

    logic [7:0]     txr_val;
    logic [7:0]     cr_val;
    logic [7:0]     init_val;
    logic           last_step;
    logic           rd_step;

    assign wb.m_stb_o = stb_q;
    assign wb.m_cyc_o = stb_q;
    assign wb.m_we_o  = we_q;
    assign wb.m_adr_o = adr_q;
    assign wb.m_dat_o = dat_q;

    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_RESP);

    // Step 3 only exists for reads: the RD command, after which RxACK is
    // our own NACK and must not be treated as an error.
    assign rd_step   = rnw_q && (step_q == 2'd3);
    assign last_step = rnw_q ? (step_q == 2'd3) : (step_q == 2'd2);

    always_comb begin
        txr_val = 8'h00;
        cr_val  = 8'h00;
        case (step_q)
            2'd0: begin
                txr_val = {dev_q, 1'b0};
                cr_val  = CR_STA_WR;
            end
            2'd1: begin
                txr_val = reg_q;
                cr_val  = CR_WR;
            end
            2'd2: begin
                if (rnw_q) begin
                    txr_val = {dev_q, 1'b1};
                    cr_val  = CR_STA_WR;
                end else begin
                    txr_val = wdata_q;
                    cr_val  = CR_STO_WR;
                end
            end
            default: begin
                txr_val = 8'h00;
                cr_val  = CR_RD_NACK_STO;
            end
        endcase
    end

    always_comb begin
        init_val = CTR_EN;
        case (step_q)
            2'd0:    init_val = PRESCALE[7:0];
            2'd1:    init_val = PRESCALE[15:8];
            default: init_val = CTR_EN;
        endcase
    end

    // Each access state launches a bus cycle when the strobe is low and
    // advances on the acknowledge. The strobe always drops on the ack edge,
    // which yields the mandatory idle cycle before the next launch.
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q     <= ST_INIT;
            step_q      <= 2'd0;
            poll_q      <= '0;
            err_q       <= ERR_OK;
            rnw_q       <= 1'b0;
            dev_q       <= 7'h00;
            reg_q       <= 8'h00;
            wdata_q     <= 8'h00;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 3'd0;
            dat_q       <= 8'h00;
            rsp_rdata_o <= 8'h00;
            rsp_err_o   <= ERR_OK;
            init_done_o <= 1'b0;
        end else begin
            if (stb_q && wb.m_ack_i) begin
                stb_q <= 1'b0;
            end
            case (state_q)
                ST_INIT: begin
                    if (!stb_q) begin
                        stb_q <= 1'b1;
                        we_q  <= 1'b1;
                        adr_q <= {1'b0, step_q};
                        dat_q <= init_val;
                    end else if (wb.m_ack_i) begin
                        if (step_q == 2'd2) begin
                            init_done_o <= 1'b1;
                            step_q      <= 2'd0;
                            state_q     <= ST_IDLE;
                        end else begin
                            step_q <= step_q + 2'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    // The first TXR write goes out straight from the request
                    // inputs so the strobe rises the cycle after acceptance.
                    if (req_valid_i) begin
                        rnw_q   <= req_rnw_i;
                        dev_q   <= req_dev_i;
                        reg_q   <= req_reg_i;
                        wdata_q <= req_wdata_i;
                        step_q  <= 2'd0;
                        err_q   <= ERR_OK;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b1;
                        adr_q   <= ADR_TXR;
                        dat_q   <= {req_dev_i, 1'b0};
                        state_q <= ST_TXR;
                    end
                end
                ST_TXR: begin
                    if (!stb_q) begin
                        stb_q <= 1'b1;
                        we_q  <= 1'b1;
                        adr_q <= ADR_TXR;
                        dat_q <= txr_val;
                    end else if (wb.m_ack_i) begin
                        state_q <= ST_CR;
                    end
                end
                ST_CR: begin
                    if (!stb_q) begin
                        stb_q <= 1'b1;
                        we_q  <= 1'b1;
                        adr_q <= ADR_CR;
                        dat_q <= cr_val;
                    end else if (wb.m_ack_i) begin
                        poll_q  <= '0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!stb_q) begin
                        stb_q <= 1'b1;
                        we_q  <= 1'b0;
                        adr_q <= ADR_CR;
                    end else if (wb.m_ack_i) begin
                        if (wb.m_dat_i[1]) begin
                            if (poll_q == POLL_LAST) begin
                                rsp_err_o   <= ERR_TMO;
                                rsp_rdata_o <= 8'h00;
                                state_q     <= ST_RESP;
                            end else begin
                                poll_q <= poll_q + 1'b1;
                            end
                        end else if (wb.m_dat_i[5]) begin
                            err_q   <= ERR_AL;
                            poll_q  <= '0;
                            state_q <= ST_DRAIN;
                        end else if (wb.m_dat_i[7] && !rd_step) begin
                            err_q   <= ERR_NACK;
                            state_q <= ST_STO;
                        end else if (last_step) begin
                            if (rnw_q) begin
                                state_q <= ST_RXR;
                            end else begin
                                rsp_err_o   <= ERR_OK;
                                rsp_rdata_o <= 8'h00;
                                state_q     <= ST_RESP;
                            end
                        end else begin
                            step_q  <= step_q + 2'd1;
                            // The RD step has no TXR payload.
                            state_q <= (rnw_q && step_q == 2'd2) ? ST_CR : ST_TXR;
                        end
                    end
                end
                ST_STO: begin
                    if (!stb_q) begin
                        stb_q <= 1'b1;
                        we_q  <= 1'b1;
                        adr_q <= ADR_CR;
                        dat_q <= CR_STO;
                    end else if (wb.m_ack_i) begin
                        poll_q  <= '0;
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!stb_q) begin
                        stb_q <= 1'b1;
                        we_q  <= 1'b0;
                        adr_q <= ADR_CR;
                    end else if (wb.m_ack_i) begin
                        if (!wb.m_dat_i[6]) begin
                            rsp_err_o   <= err_q;
                            rsp_rdata_o <= 8'h00;
                            state_q     <= ST_RESP;
                        end else if (poll_q == POLL_LAST) begin
                            rsp_err_o   <= ERR_TMO;
                            rsp_rdata_o <= 8'h00;
                            state_q     <= ST_RESP;
                        end else begin
                            poll_q <= poll_q + 1'b1;
                        end
                    end
                end
                ST_RXR: begin
                    if (!stb_q) begin
                        stb_q <= 1'b1;
                        we_q  <= 1'b0;
                        adr_q <= ADR_TXR;
                    end else if (wb.m_ack_i) begin
                        rsp_err_o   <= ERR_OK;
                        rsp_rdata_o <= wb.m_dat_i;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_INIT;
                    step_q  <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Directed bench for i2c_xfer_sequencer with a 1-cycle-ack core model that
// logs register writes and returns scripted SR values.
module tb_i2c_xfer_sequencer;

    localparam int unsigned POLL_MAX = 4;

    logic       wb_clk_i = 1'b0;
    logic       arst_i = 1'b0;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic       req_rnw_i = 1'b0;
    logic [6:0] req_dev_i = 7'h00;
    logic [7:0] req_reg_i = 8'h00;
    logic [7:0] req_wdata_i = 8'h00;
    logic       rsp_valid_o;
    logic [7:0] rsp_rdata_o;
    logic [1:0] rsp_err_o;
    logic       init_done_o;

    i2c_xfer_sequencer_if bus();

    i2c_xfer_sequencer #(
        .PRESCALE (16'h0031),
        .POLL_MAX (POLL_MAX)
    ) dut (
        .wb_clk_i    (wb_clk_i),
        .arst_i      (arst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_rnw_i   (req_rnw_i),
        .req_dev_i   (req_dev_i),
        .req_reg_i   (req_reg_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .init_done_o (init_done_o),
        .wb          (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // core model
    logic        ack_r = 1'b0;
    logic [7:0]  dat_r = 8'h00;
    logic [7:0]  sr_q[$];
    logic [7:0]  sr_default = 8'h00;
    logic [7:0]  rxr_val = 8'h00;
    logic [10:0] wlog[$];
    int          sr_reads = 0;
    int          cyc_n = 0;
    int          last_ack = 0;

    assign bus.m_ack_i = ack_r;
    assign bus.m_dat_i = dat_r;

    always @(posedge wb_clk_i) begin
        cyc_n <= cyc_n + 1;
        if (bus.m_cyc_o && bus.m_stb_o && !ack_r) begin
            ack_r <= 1'b1;
            if (bus.m_we_o) begin
                wlog.push_back({bus.m_adr_o, bus.m_dat_o});
            end else if (bus.m_adr_o == 3'd4) begin
                sr_reads = sr_reads + 1;
                if (sr_q.size() > 0) dat_r <= sr_q.pop_front();
                else                 dat_r <= sr_default;
            end else if (bus.m_adr_o == 3'd3) begin
                dat_r <= rxr_val;
            end else begin
                dat_r <= 8'h00;
            end
        end else begin
            ack_r <= 1'b0;
        end
    end

    always @(negedge wb_clk_i) begin
        if (bus.m_ack_i && bus.m_stb_o) last_ack <= cyc_n;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // exp_v holds n entries {adr,dat}, first entry in the most significant slot
    task automatic chk_log(input string tag, input logic [76:0] exp_v, input int n);
        chk({tag, "_len"}, wlog.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < wlog.size()) chk(tag, wlog[i], exp_v[(n-1-i)*11 +: 11]);
        end
    endtask

    task automatic wait_init(output bit early);
        early = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge wb_clk_i);
            if (req_ready_o && !init_done_o) early = 1'b1;
            if (init_done_o) break;
        end
    endtask

    task automatic do_xfer(input logic rnw, input logic [6:0] dev, input logic [7:0] rg,
                           input logic [7:0] wd, input bit hs);
        int n;
        wlog.delete();
        sr_reads = 0;
        n = 0;
        while (!req_ready_o && n < 100) begin
            @(negedge wb_clk_i);
            n++;
        end
        req_rnw_i   = rnw;
        req_dev_i   = dev;
        req_reg_i   = rg;
        req_wdata_i = wd;
        req_valid_i = 1'b1;
        @(negedge wb_clk_i);
        req_valid_i = 1'b0;
        if (hs) begin
            chk("acc_stb", bus.m_stb_o, 1'b1);
            chk("acc_cyc", bus.m_cyc_o, 1'b1);
            chk("acc_rdy", req_ready_o, 1'b0);
        end
        n = 0;
        while (!rsp_valid_o && n < 400) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("rsp_valid", rsp_valid_o, 1'b1);
        if (hs) begin
            @(negedge wb_clk_i);
            chk("rsp_pulse", rsp_valid_o, 1'b0);
            chk("rdy_after", req_ready_o, 1'b1);
        end
    endtask

    initial begin
        bit early;
        int n;

        // reset state
        repeat (3) @(negedge wb_clk_i);
        chk("rst_ready", req_ready_o, 1'b0);
        chk("rst_rsp",   rsp_valid_o, 1'b0);
        chk("rst_init",  init_done_o, 1'b0);
        chk("rst_stb",   bus.m_stb_o, 1'b0);
        chk("rst_err",   rsp_err_o, 2'b00);

        // init sequence
        arst_i = 1'b1;
        wait_init(early);
        chk("init_done",  init_done_o, 1'b1);
        chk("init_lat",   cyc_n - last_ack, 1);
        chk("init_early", early, 1'b0);
        chk("init_ready", req_ready_o, 1'b1);
        chk_log("init_log", {11'h031, 11'h100, 11'h280}, 3);

        // write with ACKs, one TIP poll in the first two waits
        sr_q = '{8'h02, 8'h00, 8'h02, 8'h00, 8'h00};
        do_xfer(1'b0, 7'h50, 8'h12, 8'hA5, 1'b1);
        chk("wr_err", rsp_err_o, 2'b00);
        chk("wr_rd0", rsp_rdata_o, 8'h00);
        chk_log("wr_log", {11'h3A0, 11'h490, 11'h312, 11'h410, 11'h3A5, 11'h450}, 6);

        // read; RxACK after the RD command must be ignored
        sr_q = '{8'h00, 8'h00, 8'h00, 8'h80};
        rxr_val = 8'h3C;
        do_xfer(1'b1, 7'h50, 8'h03, 8'h00, 1'b0);
        chk("rd_err",  rsp_err_o, 2'b00);
        chk("rd_data", rsp_rdata_o, 8'h3C);
        chk_log("rd_log", {11'h3A0, 11'h490, 11'h303, 11'h410, 11'h3A1, 11'h490, 11'h468}, 7);
        repeat (3) @(negedge wb_clk_i);
        chk("rd_hold", rsp_rdata_o, 8'h3C);

        // address NACK, drain until bus free
        sr_q = '{8'h80, 8'h40, 8'h00};
        do_xfer(1'b0, 7'h50, 8'h12, 8'hA5, 1'b0);
        chk("nack_err",  rsp_err_o, 2'b01);
        chk("nack_data", rsp_rdata_o, 8'h00);
        chk("nack_srrd", sr_reads, 3);
        chk_log("nack_log", {11'h3A0, 11'h490, 11'h440}, 3);

        // arbitration lost on the register byte
        sr_q = '{8'h00, 8'h20, 8'h00};
        do_xfer(1'b0, 7'h50, 8'h12, 8'hA5, 1'b0);
        chk("al_err", rsp_err_o, 2'b10);
        chk_log("al_log", {11'h3A0, 11'h490, 11'h312, 11'h410}, 4);

        // TIP stuck: POLL_MAX reads then timeout
        sr_q.delete();
        sr_default = 8'h02;
        do_xfer(1'b0, 7'h50, 8'h12, 8'hA5, 1'b0);
        chk("tmo_err",  rsp_err_o, 2'b11);
        chk("tmo_srrd", sr_reads, POLL_MAX);
        chk_log("tmo_log", {11'h3A0, 11'h490}, 2);

        // reset in the middle of a WAIT
        n = 0;
        while (!req_ready_o && n < 20) begin
            @(negedge wb_clk_i);
            n++;
        end
        req_rnw_i   = 1'b0;
        req_valid_i = 1'b1;
        @(negedge wb_clk_i);
        req_valid_i = 1'b0;
        n = 0;
        while (!(bus.m_stb_o && !bus.m_we_o && bus.m_adr_o == 3'd4) && n < 100) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("mid_wait_seen", bus.m_stb_o && !bus.m_we_o, 1'b1);
        #2 arst_i = 1'b0;
        #1;
        chk("arst_stb",   bus.m_stb_o, 1'b0);
        chk("arst_cyc",   bus.m_cyc_o, 1'b0);
        chk("arst_rsp",   rsp_valid_o, 1'b0);
        chk("arst_ready", req_ready_o, 1'b0);
        chk("arst_init",  init_done_o, 1'b0);
        repeat (2) @(negedge wb_clk_i);
        sr_default = 8'h00;
        wlog.delete();
        arst_i = 1'b1;
        wait_init(early);
        chk("reinit_done",  init_done_o, 1'b1);
        chk("reinit_early", early, 1'b0);
        chk("reinit_ready", req_ready_o, 1'b1);
        chk_log("reinit_log", {11'h031, 11'h100, 11'h280}, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
